// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing generator for the game display path. One pixel-divider
// counter plus horizontal and vertical position counters drive a registered
// decode of sync, display-area qualifier, scaled pixel coordinates and
// line/frame start strobes. Every output is the decode of the counter state
// held in the previous clock, so all outputs change together on the clock
// edge and are glitch-free.
//
// Segment order on each axis: sync, back porch, active, front porch.
// There is no handshake on this block: it free-runs from reset and
// downstream logic qualifies on pix_tick / display_area.

module vga_timing_gen #(
    parameter int CLK_DIV     = 2,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter bit HSYNC_POL   = 1'b0,
    parameter bit VSYNC_POL   = 1'b0,
    parameter int SCALE_SHIFT = 0,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          rst,
    output logic          hsync,
    output logic          vsync,
    output logic          display_area,
    output logic [AW-1:0] haddr,
    output logic [AW-1:0] vaddr,
    output logic          pix_tick,
    output logic          line_start,
    output logic          frame_start
);

    // ------------------------------------------------------------------
    // Derived geometry
    // ------------------------------------------------------------------
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    // Counter widths; a degenerate count of 1 still gets a 1-bit register.
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    // Decode boundaries held at 32 bits so that a boundary equal to the
    // total (no front porch) never overflows the counter width.
    localparam logic [31:0] DIV_LAST  = 32'(CLK_DIV - 1);
    localparam logic [31:0] H_LAST    = 32'(H_TOTAL - 1);
    localparam logic [31:0] V_LAST    = 32'(V_TOTAL - 1);
    localparam logic [31:0] H_SYNC_END = 32'(H_SYNC);
    localparam logic [31:0] V_SYNC_END = 32'(V_SYNC);
    localparam logic [31:0] H_ACT_LO  = 32'(H_SYNC + H_BP);
    localparam logic [31:0] H_ACT_HI  = 32'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [31:0] V_ACT_LO  = 32'(V_SYNC + V_BP);
    localparam logic [31:0] V_ACT_HI  = 32'(V_SYNC + V_BP + V_ACTIVE);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $fatal(1, "vga_timing_gen: CLK_DIV must be at least 1");
    end

    if ((64'(H_ACTIVE - 1) >> SCALE_SHIFT) >= (64'd1 << AW)) begin : g_bad_haddr_width
        $fatal(1, "vga_timing_gen: scaled H_ACTIVE does not fit in AW bits");
    end

    if ((64'(V_ACTIVE - 1) >> SCALE_SHIFT) >= (64'd1 << AW)) begin : g_bad_vaddr_width
        $fatal(1, "vga_timing_gen: scaled V_ACTIVE does not fit in AW bits");
    end

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [DW-1:0] div_cnt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    logic div_last;
    logic h_last;
    logic v_last;

    // End-of-pixel, end-of-line and end-of-frame conditions
    always_comb begin
        div_last = (32'(div_cnt) == DIV_LAST);
        h_last   = (32'(h_cnt) == H_LAST);
        v_last   = (32'(v_cnt) == V_LAST);
    end

    // Advance divider every clock, column on each pixel, row on each line wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            if (div_last) begin
                div_cnt <= '0;
                if (h_last) begin
                    h_cnt <= '0;
                    if (v_last) begin
                        v_cnt <= '0;
                    end else begin
                        v_cnt <= v_cnt + VW'(1);
                    end
                end else begin
                    h_cnt <= h_cnt + HW'(1);
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode of the current counter state
    // ------------------------------------------------------------------
    logic [31:0]   h_pos;
    logic [31:0]   v_pos;
    logic [31:0]   h_rel;
    logic [31:0]   v_rel;
    logic          h_act;
    logic          v_act;
    logic          hsync_d;
    logic          vsync_d;
    logic          display_area_d;
    logic [AW-1:0] haddr_d;
    logic [AW-1:0] vaddr_d;
    logic          pix_tick_d;
    logic          line_start_d;
    logic          frame_start_d;

    // Combinational decode feeding the output registers
    always_comb begin
        h_pos = 32'(h_cnt);
        v_pos = 32'(v_cnt);

        h_act = (h_pos >= H_ACT_LO) && (h_pos < H_ACT_HI);
        v_act = (v_pos >= V_ACT_LO) && (v_pos < V_ACT_HI);

        // Offsets into the active window; only meaningful when *_act is set.
        h_rel = h_pos - H_ACT_LO;
        v_rel = v_pos - V_ACT_LO;

        hsync_d = (h_pos < H_SYNC_END) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d = (v_pos < V_SYNC_END) ? VSYNC_POL : ~VSYNC_POL;

        display_area_d = h_act && v_act;

        // vaddr follows the row alone so the frame-buffer row fetch can
        // start during horizontal blanking of an active line.
        haddr_d = h_act ? AW'(h_rel >> SCALE_SHIFT) : '0;
        vaddr_d = v_act ? AW'(v_rel >> SCALE_SHIFT) : '0;

        pix_tick_d    = div_last;
        line_start_d  = (h_cnt == '0) && (div_cnt == '0);
        frame_start_d = line_start_d && (v_cnt == '0);
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------

    // Register the decode; reset parks syncs deasserted and strobes low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync        <= ~HSYNC_POL;
            vsync        <= ~VSYNC_POL;
            display_area <= 1'b0;
            haddr        <= '0;
            vaddr        <= '0;
            pix_tick     <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            hsync        <= hsync_d;
            vsync        <= vsync_d;
            display_area <= display_area_d;
            haddr        <= haddr_d;
            vaddr        <= vaddr_d;
            pix_tick     <= pix_tick_d;
            line_start   <= line_start_d;
            frame_start  <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Three generator instances share clk/rst:
//   a: default horizontal geometry, CLK_DIV=2, short vertical (2/3/4/1)
//   b: CLK_DIV=1, SCALE_SHIFT=1, HSYNC_POL=1, short vertical (2/1/8/1)
//   c: small geometry H 2/1/4/1, V 1/1/3/1, CLK_DIV=3
// Expected outputs come from a reference model that derives position
// directly from the clock count since reset release.

module tb_vga_timing_gen;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   cd;
    int   h_s;
    int   h_b;
    int   h_a;
    int   h_f;
    int   v_s;
    int   v_b;
    int   v_a;
    int   v_f;
    logic hp;
    logic vp;
    int   sh;
  } cfg_t;

  cfg_t cfg_a;
  cfg_t cfg_b;
  cfg_t cfg_c;

  int total = 0;
  int bad   = 0;
  logic [25:0] exp_q[$];

  // DUT a
  logic hsync_a, vsync_a, da_a, pt_a, ls_a, fs_a;
  logic [9:0] haddr_a, vaddr_a;
  logic [25:0] act_a;
  assign act_a = {hsync_a, vsync_a, da_a, pt_a, ls_a, fs_a, haddr_a, vaddr_a};

  vga_timing_gen #(
    .CLK_DIV(2), .V_SYNC(2), .V_BP(3), .V_ACTIVE(4), .V_FP(1)
  ) dut_a (
    .clk(clk), .rst(rst), .hsync(hsync_a), .vsync(vsync_a), .display_area(da_a),
    .haddr(haddr_a), .vaddr(vaddr_a), .pix_tick(pt_a), .line_start(ls_a), .frame_start(fs_a)
  );

  // DUT b
  logic hsync_b, vsync_b, da_b, pt_b, ls_b, fs_b;
  logic [9:0] haddr_b, vaddr_b;
  logic [25:0] act_b;
  assign act_b = {hsync_b, vsync_b, da_b, pt_b, ls_b, fs_b, haddr_b, vaddr_b};

  vga_timing_gen #(
    .CLK_DIV(1), .V_SYNC(2), .V_BP(1), .V_ACTIVE(8), .V_FP(1),
    .HSYNC_POL(1'b1), .SCALE_SHIFT(1)
  ) dut_b (
    .clk(clk), .rst(rst), .hsync(hsync_b), .vsync(vsync_b), .display_area(da_b),
    .haddr(haddr_b), .vaddr(vaddr_b), .pix_tick(pt_b), .line_start(ls_b), .frame_start(fs_b)
  );

  // DUT c
  logic hsync_c, vsync_c, da_c, pt_c, ls_c, fs_c;
  logic [9:0] haddr_c, vaddr_c;
  logic [25:0] act_c;
  assign act_c = {hsync_c, vsync_c, da_c, pt_c, ls_c, fs_c, haddr_c, vaddr_c};

  vga_timing_gen #(
    .CLK_DIV(3), .H_SYNC(2), .H_BP(1), .H_ACTIVE(4), .H_FP(1),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1)
  ) dut_c (
    .clk(clk), .rst(rst), .hsync(hsync_c), .vsync(vsync_c), .display_area(da_c),
    .haddr(haddr_c), .vaddr(vaddr_c), .pix_tick(pt_c), .line_start(ls_c), .frame_start(fs_c)
  );

  // reference model: outputs seen after the (t+1)-th clock following release
  function automatic logic [25:0] model(input cfg_t c, input int t);
    int ht, vt, pix, dv, h, v;
    logic hs, vs, ha, va, pt, ls, fs;
    logic [9:0] hx, vx;
    ht  = c.h_s + c.h_b + c.h_a + c.h_f;
    vt  = c.v_s + c.v_b + c.v_a + c.v_f;
    dv  = t % c.cd;
    pix = t / c.cd;
    h   = pix % ht;
    v   = (pix / ht) % vt;
    hs  = (h < c.h_s) ? c.hp : ~c.hp;
    vs  = (v < c.v_s) ? c.vp : ~c.vp;
    ha  = (h >= c.h_s + c.h_b) && (h < c.h_s + c.h_b + c.h_a);
    va  = (v >= c.v_s + c.v_b) && (v < c.v_s + c.v_b + c.v_a);
    hx  = ha ? 10'((h - c.h_s - c.h_b) >> c.sh) : 10'd0;
    vx  = va ? 10'((v - c.v_s - c.v_b) >> c.sh) : 10'd0;
    pt  = (dv == c.cd - 1);
    ls  = (h == 0) && (dv == 0);
    fs  = ls && (v == 0);
    return {hs, vs, ha && va, pt, ls, fs, hx, vx};
  endfunction

  function automatic logic [25:0] reset_vec(input cfg_t c);
    return {~c.hp, ~c.vp, 24'd0};
  endfunction

  // driver: pulse reset, release just after a falling edge
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (act_a !== reset_vec(cfg_a)) begin
      bad++; $display("FAIL reset_a got=%h exp=%h", act_a, reset_vec(cfg_a));
    end
    total++;
    if (act_b !== reset_vec(cfg_b)) begin
      bad++; $display("FAIL reset_b got=%h exp=%h", act_b, reset_vec(cfg_b));
    end
    total++;
    if (act_c !== reset_vec(cfg_c)) begin
      bad++; $display("FAIL reset_c got=%h exp=%h", act_c, reset_vec(cfg_c));
    end
  endtask

  task automatic test_reset_release();
    logic [25:0] e;
    int hs_low = 0;
    bit hs_done = 1'b0;
    int next_ls = -1;
    do_reset();
    for (int k = 0; k <= 1700; k++) begin
      exp_q.push_back(model(cfg_a, k));
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (act_a !== e) begin
        bad++; $display("FAIL rel_sb k=%0d got=%h exp=%h", k, act_a, e);
      end
      if (k == 0) begin
        total++;
        if ({hsync_a, vsync_a, ls_a, fs_a} !== 4'b0011) begin
          bad++; $display("FAIL rel_first got=%b exp=0011", {hsync_a, vsync_a, ls_a, fs_a});
        end
      end
      if (!hs_done) begin
        if (hsync_a === 1'b0) hs_low++;
        else hs_done = 1'b1;
      end
      if (k > 0 && next_ls < 0 && ls_a === 1'b1) next_ls = k;
    end
    total++;
    if (hs_low !== 192) begin
      bad++; $display("FAIL rel_hsync_low got=%0d exp=192", hs_low);
    end
    total++;
    if (next_ls !== 1600) begin
      bad++; $display("FAIL rel_next_line got=%0d exp=1600", next_ls);
    end
  endtask

  task automatic test_active_window();
    logic [25:0] e;
    int rise = -1;
    int hi_len = 0;
    bit fell = 1'b0;
    do_reset();
    for (int k = 0; k < 9600; k++) begin
      exp_q.push_back(model(cfg_a, k));
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (act_a !== e) begin
        bad++; $display("FAIL act_sb k=%0d got=%h exp=%h", k, act_a, e);
      end
      if (rise < 0 && da_a === 1'b1) rise = k;
      if (rise >= 0 && !fell) begin
        if (da_a === 1'b1) hi_len++;
        else fell = 1'b1;
      end
      if (k >= 8288 && k <= 9568) begin
        total++;
        if (k < 9568 && haddr_a !== 10'((k - 8288) / 2)) begin
          bad++; $display("FAIL act_haddr k=%0d got=%0d exp=%0d", k, haddr_a, (k - 8288) / 2);
        end else if (k == 9568 && haddr_a !== 10'd0) begin
          bad++; $display("FAIL act_haddr_end got=%0d exp=0", haddr_a);
        end
      end
    end
    total++;
    if (rise !== 8288) begin
      bad++; $display("FAIL act_rise got=%0d exp=8288", rise);
    end
    total++;
    if (hi_len !== 1280) begin
      bad++; $display("FAIL act_len got=%0d exp=1280", hi_len);
    end
  endtask

  task automatic test_frame();
    logic [25:0] e;
    int vs_low = 0;
    bit vs_done = 1'b0;
    int fs2 = -1;
    int line;
    do_reset();
    for (int k = 0; k < 19300; k++) begin
      exp_q.push_back(model(cfg_a, k));
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (act_a !== e) begin
        bad++; $display("FAIL frm_sb k=%0d got=%h exp=%h", k, act_a, e);
      end
      if (!vs_done) begin
        if (vsync_a === 1'b0) vs_low++;
        else vs_done = 1'b1;
      end
      if (k > 0 && fs2 < 0 && fs_a === 1'b1) fs2 = k;
      line = k / 1600;
      if (k % 1600 == 288 && line >= 4 && line <= 9) begin
        total++;
        if (vaddr_a !== ((line >= 5 && line <= 8) ? 10'(line - 5) : 10'd0)) begin
          bad++; $display("FAIL frm_vaddr line=%0d got=%0d", line, vaddr_a);
        end
      end
      if (k == 6 * 1600 + 10) begin
        total++;
        if ({da_a, vaddr_a} !== {1'b0, 10'd1}) begin
          bad++; $display("FAIL frm_vaddr_blank got=%b/%0d exp=0/1", da_a, vaddr_a);
        end
      end
    end
    total++;
    if (vs_low !== 3200) begin
      bad++; $display("FAIL frm_vsync_low got=%0d exp=3200", vs_low);
    end
    total++;
    if (fs2 !== 16000) begin
      bad++; $display("FAIL frm_period got=%0d exp=16000", fs2);
    end
  endtask

  task automatic test_div1_scale();
    logic [25:0] e;
    int pt_zero = 0;
    int hs_high = 0;
    bit hs_done = 1'b0;
    int max_h = 0;
    int max_v = 0;
    do_reset();
    for (int k = 0; k < 9600; k++) begin
      exp_q.push_back(model(cfg_b, k));
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (act_b !== e) begin
        bad++; $display("FAIL d1_sb k=%0d got=%h exp=%h", k, act_b, e);
      end
      if (pt_b !== 1'b1) pt_zero++;
      if (!hs_done) begin
        if (hsync_b === 1'b1) hs_high++;
        else hs_done = 1'b1;
      end
      if (int'(haddr_b) > max_h) max_h = int'(haddr_b);
      if (int'(vaddr_b) > max_v) max_v = int'(vaddr_b);
      if (k >= 3 * 800 + 144 && k < 3 * 800 + 784) begin
        total++;
        if (haddr_b !== 10'((k - 3 * 800 - 144) >> 1)) begin
          bad++; $display("FAIL d1_haddr k=%0d got=%0d exp=%0d", k, haddr_b, (k - 3 * 800 - 144) >> 1);
        end
      end
    end
    total++;
    if (pt_zero !== 0) begin
      bad++; $display("FAIL d1_pix_tick zero_clocks=%0d exp=0", pt_zero);
    end
    total++;
    if (hs_high !== 96) begin
      bad++; $display("FAIL d1_hsync_high got=%0d exp=96", hs_high);
    end
    total++;
    if (max_h !== 319 || max_v !== 3) begin
      bad++; $display("FAIL d1_max_addr got=%0d/%0d exp=319/3", max_h, max_v);
    end
  endtask

  task automatic test_mid_reset();
    logic [25:0] e;
    do_reset();
    for (int k = 0; k < 8688; k++) begin
      exp_q.push_back(model(cfg_a, k));
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (act_a !== e) begin
        bad++; $display("FAIL mid_pre k=%0d got=%h exp=%h", k, act_a, e);
      end
    end
    // assert between edges: asynchronous clear must show at once
    rst = 1'b1;
    #1;
    total++;
    if (act_a !== reset_vec(cfg_a)) begin
      bad++; $display("FAIL mid_async got=%h exp=%h", act_a, reset_vec(cfg_a));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (act_a !== reset_vec(cfg_a)) begin
        bad++; $display("FAIL mid_hold i=%0d got=%h exp=%h", i, act_a, reset_vec(cfg_a));
      end
    end
    rst = 1'b0;
    for (int k = 0; k <= 1700; k++) begin
      exp_q.push_back(model(cfg_a, k));
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (act_a !== e) begin
        bad++; $display("FAIL mid_post k=%0d got=%h exp=%h", k, act_a, e);
      end
    end
  endtask

  task automatic test_small_geometry();
    logic [25:0] e;
    do_reset();
    for (int k = 0; k < 2 * 144 + 6; k++) begin
      exp_q.push_back(model(cfg_c, k));
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (act_c !== e) begin
        bad++; $display("FAIL sm_sb k=%0d got=%h exp=%h", k, act_c, e);
      end
      if (k == 144 || k == 288) begin
        total++;
        if ({ls_c, fs_c} !== 2'b11) begin
          bad++; $display("FAIL sm_wrap k=%0d got=%b exp=11", k, {ls_c, fs_c});
        end
      end
      if (k == 24) begin
        total++;
        if ({ls_c, fs_c} !== 2'b10) begin
          bad++; $display("FAIL sm_line1 got=%b exp=10", {ls_c, fs_c});
        end
      end
    end
  endtask

  initial begin
    cfg_a = '{cd: 2, h_s: 96, h_b: 48, h_a: 640, h_f: 16,
              v_s: 2, v_b: 3, v_a: 4, v_f: 1, hp: 1'b0, vp: 1'b0, sh: 0};
    cfg_b = '{cd: 1, h_s: 96, h_b: 48, h_a: 640, h_f: 16,
              v_s: 2, v_b: 1, v_a: 8, v_f: 1, hp: 1'b1, vp: 1'b0, sh: 1};
    cfg_c = '{cd: 3, h_s: 2, h_b: 1, h_a: 4, h_f: 1,
              v_s: 1, v_b: 1, v_a: 3, v_f: 1, hp: 1'b0, vp: 1'b0, sh: 0};
    #1 rst = 1'b1;

    test_reset();
    test_reset_release();
    test_active_window();
    test_frame();
    test_div1_scale();
    test_mid_reset();
    test_small_geometry();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
